// File: rtl/uart_word_rx.sv
// ============================================================================
// uart_word_rx : 8N1 UART receiver; packs 4 bytes LSB-first into a 32-bit word
// delivered via start/done/result. Optional UART_WORD_RX_TIMEOUT_EN macro
// drops stale partial words.  Revision: 1.0
// ============================================================================
`default_nettype none

module uart_word_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        clock_en,
    input  logic        start,
    input  logic        rx,
    output logic        done,
    output logic [31:0] result,
    output logic        error
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_C = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic             rx_meta_q, rx_sync_q, rx_prev_q;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [1:0]       idx_q, idx_d;
    logic [23:0]      word_q, word_d;
    logic [31:0]      hold_q, hold_d;
    logic             full_q, full_d;
    logic             pending_q, pending_d;
    logic [31:0]      result_q, result_d;
    logic             error_q, error_d;

    logic rx_fall, byte_ok, frame_err, commit_word, deliver, overrun, timeout;

    assign rx_fall = rx_prev_q & ~rx_sync_q;
    assign deliver = pending_q & full_q;

`ifdef UART_WORD_RX_TIMEOUT_EN
    localparam int TO_W = $clog2(16 * CLKS_PER_BIT);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(16 * CLKS_PER_BIT - 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            to_armed;

    // Only a partial word sitting idle between bytes is subject to the timeout.
    assign to_armed = (state_q == S_IDLE) && (idx_q != 2'd0) && !rx_fall;
    assign timeout  = to_armed && (to_cnt_q == TO_LAST);
    assign to_cnt_d = (to_armed && !timeout) ? to_cnt_q + 1'b1 : '0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) to_cnt_q <= '0;
        else        to_cnt_q <= to_cnt_d;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        idx_d     = idx_q;
        word_d    = word_q;
        hold_d    = hold_q;
        full_d    = full_q;
        pending_d = pending_q;
        result_d  = result_q;
        byte_ok   = 1'b0;
        frame_err = 1'b0;
        overrun   = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (rx_fall) state_d = S_START;
            end
            S_START: begin
                if (cnt_q == HALF_C) begin
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                    state_d = rx_sync_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == LAST_C) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (cnt_q == LAST_C) begin
                    cnt_d     = '0;
                    state_d   = S_IDLE;
                    byte_ok   = rx_sync_q;
                    frame_err = ~rx_sync_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        commit_word = byte_ok && (idx_q == 2'd3);

        if (frame_err || timeout) begin
            idx_d = 2'd0;
        end else if (byte_ok) begin
            idx_d = idx_q + 2'd1;
            case (idx_q)
                2'd0:    word_d[7:0]   = shift_q;
                2'd1:    word_d[15:8]  = shift_q;
                2'd2:    word_d[23:16] = shift_q;
                default: ;
            endcase
        end

        if (deliver) begin
            full_d    = 1'b0;
            pending_d = 1'b0;
            result_d  = hold_q;
        end else if (start && clock_en) begin
            pending_d = 1'b1;
        end

        // A delivery in the same cycle frees the slot, so that is not an overrun.
        if (commit_word) begin
            if (!full_q || deliver) begin
                hold_d = {shift_q, word_q};
                full_d = 1'b1;
            end else begin
                overrun = 1'b1;
            end
        end

        error_d = frame_err | overrun | timeout;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_q     <= 3'd0;
            shift_q   <= 8'd0;
            idx_q     <= 2'd0;
            word_q    <= 24'd0;
            hold_q    <= 32'd0;
            full_q    <= 1'b0;
            pending_q <= 1'b0;
            result_q  <= 32'd0;
            error_q   <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            idx_q     <= idx_d;
            word_q    <= word_d;
            hold_q    <= hold_d;
            full_q    <= full_d;
            pending_q <= pending_d;
            result_q  <= result_d;
            error_q   <= error_d;
        end
    end

    assign done   = deliver;
    assign result = deliver ? hold_q : result_q;
    assign error  = error_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_word_rx.sv
// ============================================================================
// tb_uart_word_rx : directed self-checking bench for uart_word_rx (CLKS_PER_BIT=4).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_uart_word_rx;

    localparam int CPB = 4;

    logic        clock;
    logic        reset;
    logic        clock_en;
    logic        start;
    logic        rx;
    logic        done;
    logic [31:0] result;
    logic        error;

    int          checks;
    int          failures;
    int          cyc;
    int          done_cnt;
    int          err_cnt;
    int          done_cyc;
    int          edge_cyc;
    logic [31:0] last_result;

    uart_word_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clock    (clock),
        .reset    (reset),
        .clock_en (clock_en),
        .start    (start),
        .rx       (rx),
        .done     (done),
        .result   (result),
        .error    (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (done === 1'b1) begin
            done_cnt    <= done_cnt + 1;
            last_result <= result;
            done_cyc    <= cyc;
        end
        if (error === 1'b1) err_cnt <= err_cnt + 1;
    end

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * CPB) @(negedge clock);
    endtask

    // One frame plus one idle bit-time; entered and left on a falling clock edge.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        edge_cyc = cyc;
        rx = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clock);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clock);
        rx = 1'b1;
        repeat (CPB) @(negedge clock);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clock);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (error !== 1'b0) begin failures++; $display("FAIL reset_error got=%b exp=0", error); end
        checks++; if (result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h exp=00000000", result); end
        reset = 1'b1;
        idle_bits(2);
    endtask

    task automatic test_word_then_start();
        int e0;
        e0 = err_cnt;
        send_word(32'h12345678);
        idle_bits(2);
        checks++; if (done_cnt !== 0) begin failures++; $display("FAIL held_no_done got=%0d exp=0", done_cnt); end
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL start_done got=%b exp=1", done); end
        checks++; if (result !== 32'h12345678) begin failures++; $display("FAIL start_result got=%h exp=12345678", result); end
        @(negedge clock);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL done_one_cycle got=%b exp=0", done); end
        checks++; if (result !== 32'h12345678) begin failures++; $display("FAIL result_hold got=%h exp=12345678", result); end
        checks++; if (err_cnt !== e0) begin failures++; $display("FAIL word1_no_error got=%0d exp=%0d", err_cnt, e0); end
    endtask

    task automatic test_start_first();
        int d0, e0, lat;
        d0 = done_cnt;
        e0 = err_cnt;
        pulse_start();
        idle_bits(1);
        checks++; if (done_cnt !== d0) begin failures++; $display("FAIL early_done got=%0d exp=%0d", done_cnt, d0); end
        send_word(32'hDEADBEEF);
        idle_bits(1);
        checks++; if (done_cnt !== d0 + 1) begin failures++; $display("FAIL pending_done_cnt got=%0d exp=%0d", done_cnt, d0 + 1); end
        checks++; if (last_result !== 32'hDEADBEEF) begin failures++; $display("FAIL pending_result got=%h exp=deadbeef", last_result); end
        lat = done_cyc - edge_cyc;
        checks++; if (lat < 38 || lat > 46) begin failures++; $display("FAIL pending_latency got=%0d exp=38..46", lat); end
        checks++; if (err_cnt !== e0) begin failures++; $display("FAIL word2_no_error got=%0d exp=%0d", err_cnt, e0); end
    endtask

    task automatic test_framing();
        int d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        send_byte(8'h11, 1'b1);
        send_byte(8'h55, 1'b0);
        checks++; if (err_cnt !== e0 + 1) begin failures++; $display("FAIL framing_error got=%0d exp=%0d", err_cnt, e0 + 1); end
        send_word(32'h04030201);
        pulse_start();
        idle_bits(1);
        checks++; if (done_cnt !== d0 + 1) begin failures++; $display("FAIL framing_done_cnt got=%0d exp=%0d", done_cnt, d0 + 1); end
        checks++; if (last_result !== 32'h04030201) begin failures++; $display("FAIL framing_result got=%h exp=04030201", last_result); end
    endtask

    task automatic test_overrun();
        int d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        send_word(32'h00000001);
        send_word(32'h00000002);
        checks++; if (err_cnt !== e0 + 1) begin failures++; $display("FAIL overrun_error got=%0d exp=%0d", err_cnt, e0 + 1); end
        pulse_start();
        idle_bits(1);
        checks++; if (last_result !== 32'h00000001) begin failures++; $display("FAIL overrun_result got=%h exp=00000001", last_result); end
        pulse_start();
        idle_bits(8);
        checks++; if (done_cnt !== d0 + 1) begin failures++; $display("FAIL second_request_waits got=%0d exp=%0d", done_cnt, d0 + 1); end
        // The outstanding request is satisfied by the next complete word.
        send_word(32'hCAFEF00D);
        idle_bits(1);
        checks++; if (last_result !== 32'hCAFEF00D) begin failures++; $display("FAIL late_word_result got=%h exp=cafef00d", last_result); end
        checks++; if (done_cnt !== d0 + 2) begin failures++; $display("FAIL late_word_done_cnt got=%0d exp=%0d", done_cnt, d0 + 2); end
    endtask

    task automatic test_clock_en_and_reset();
        int d0;
        send_word(32'h0BADF00D);
        d0 = done_cnt;
        clock_en = 1'b0;
        pulse_start();
        idle_bits(8);
        clock_en = 1'b1;
        checks++; if (done_cnt !== d0) begin failures++; $display("FAIL clock_en_ignored got=%0d exp=%0d", done_cnt, d0); end
        rx = 1'b0;
        repeat (3 * CPB) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL midreset_done got=%b exp=0", done); end
        checks++; if (error !== 1'b0) begin failures++; $display("FAIL midreset_error got=%b exp=0", error); end
        checks++; if (result !== 32'h0) begin failures++; $display("FAIL midreset_result got=%h exp=00000000", result); end
        rx = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        idle_bits(2);
        d0 = done_cnt;
        pulse_start();
        idle_bits(8);
        checks++; if (done_cnt !== d0) begin failures++; $display("FAIL held_word_cleared got=%0d exp=%0d", done_cnt, d0); end
        send_word(32'h87654321);
        idle_bits(1);
        checks++; if (last_result !== 32'h87654321) begin failures++; $display("FAIL post_reset_result got=%h exp=87654321", last_result); end
        checks++; if (done_cnt !== d0 + 1) begin failures++; $display("FAIL post_reset_done_cnt got=%0d exp=%0d", done_cnt, d0 + 1); end
    endtask

    task automatic test_partial_idle();
        int e0;
        e0 = err_cnt;
        send_byte(8'hAA, 1'b1);
        idle_bits(20);
`ifdef UART_WORD_RX_TIMEOUT_EN
        checks++; if (err_cnt !== e0 + 1) begin failures++; $display("FAIL timeout_error got=%0d exp=%0d", err_cnt, e0 + 1); end
        send_word(32'h04030201);
        pulse_start();
        idle_bits(1);
        checks++; if (last_result !== 32'h04030201) begin failures++; $display("FAIL timeout_result got=%h exp=04030201", last_result); end
`else
        checks++; if (err_cnt !== e0) begin failures++; $display("FAIL idle_no_error got=%0d exp=%0d", err_cnt, e0); end
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h03, 1'b1);
        pulse_start();
        idle_bits(1);
        checks++; if (last_result !== 32'h030201AA) begin failures++; $display("FAIL idle_keep_result got=%h exp=030201aa", last_result); end
`endif
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        cyc         = 0;
        done_cnt    = 0;
        err_cnt     = 0;
        done_cyc    = 0;
        edge_cyc    = 0;
        last_result = 32'h0;
        reset       = 1'b0;
        clock_en    = 1'b1;
        start       = 1'b0;
        rx          = 1'b1;
        @(negedge clock);
        test_reset();
        test_word_then_start();
        test_start_first();
        test_framing();
        test_overrun();
        test_clock_en_and_reset();
        test_partial_idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout reached");
        $fatal(1, "bench timeout");
    end

endmodule

`default_nettype wire

// File: doc/uart_word_rx.md
# uart_word_rx

Receive-side counterpart to the UART word transmitter. Deserialises an 8N1 UART stream on `rx` and assembles four consecutive bytes into one 32-bit word. It hands the word to the processor through a Nios II-style custom-instruction handshake (`start`/`done`/`result`). It holds one completed word so that a word arriving before the request is not lost.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per UART bit (50 MHz / 115200). Minimum legal value is 4.
- `clock`  in  1: system clock; all logic on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `clock_en`  in  1: qualifies `start`; a `start` with `clock_en`=0 is ignored.
- `start`  in  1: one-cycle request for the next word.
- `rx`  in  1: asynchronous UART serial input, idle high.
- `done`  out  1: one-cycle pulse; `result` is valid in the same cycle.
- `result`  out  32: delivered word; holds its value until the next `done`.
- `error`  out  1: one-cycle pulse on a framing error, overrun or timeout.

## Operation
- `rx` passes through a 2-flop synchroniser. Both flops reset to 1.
- Bit FSM states:
  - IDLE: a falling edge of the synchronised `rx` moves to START.
  - START: at count `CLKS_PER_BIT/2`, `rx`=0 moves to DATA; `rx`=1 is a glitch and returns to IDLE with no error.
  - DATA: samples 8 bits, LSB first, one every `CLKS_PER_BIT` cycles from the start-bit midpoint.
  - STOP: samples the stop bit. `rx`=1 commits the byte. `rx`=0 is a framing error: the byte and the partial word are discarded and `error` pulses. The FSM returns to IDLE in both cases.
- Byte assembly:
  - A 2-bit byte index places byte k at `word[8k+7:8k]`. The first byte received lands in bits 7:0.
  - Committing byte 3 moves the assembled word into the holding register, sets `full`, and wraps the index to 0.
- Overrun: if byte 3 commits while `full`=1, the new word is dropped, the holding register keeps the old word, and `error` pulses.
- Request side:
  - A qualified `start` sets `pending`.
  - When `pending`=1 and `full`=1: `done` pulses, `result` loads the held word, and `pending` and `full` both clear.
  - A `start` while `pending`=1 is ignored. No queued second request exists.
- Simultaneous events:
  - Word commit and qualified `start` in the same cycle: the request sees the word one cycle later.
  - Word commit and delivery in the same cycle: the holding register is freed and accepts the new word. This is not an overrun.
- Reset mid-frame discards the partial byte, the partial word, the held word and `pending`.

## Timing
- Reset values: `done`=0, `result`=0, `error`=0. FSM in IDLE, byte index 0, `full`=0, `pending`=0.
- The synchroniser adds 2 cycles of latency from the `rx` pin to the FSM.
- Byte commit happens at the stop-bit midpoint, approximately (9.5 × `CLKS_PER_BIT` + 2) cycles after the `rx` falling edge.
- Request pending when byte 3 commits in cycle N: `done` and `result` appear in cycle N+1.
- Word already held when a qualified `start` arrives in cycle N: `done` appears in cycle N+1.
- `done` and `error` are strictly one cycle wide.

## Configuration
- `UART_WORD_RX_TIMEOUT_EN` defined:
  - Applies when the byte index is nonzero.
  - If no start bit is detected within 16 × `CLKS_PER_BIT` cycles after a stop bit, the partial word is discarded, the index returns to 0, and `error` pulses.
- `UART_WORD_RX_TIMEOUT_EN` undefined:
  - No timeout counter is built; partial words wait indefinitely.
  - `error` pulses only for framing errors and overrun.

## Test plan
- Test parameter: `CLKS_PER_BIT`=4.
- Send bytes 0x78, 0x56, 0x34, 0x12, then pulse `start` → `done` one cycle later with `result`=0x12345678; `error` never pulses.
- Pulse `start` first, then send 0xEF, 0xBE, 0xAD, 0xDE → `done` in the cycle after the 4th stop-bit sample, `result`=0xDEADBEEF.
- Send 0x11, then a byte with stop bit = 0, then 0x01, 0x02, 0x03, 0x04, then `start` → one `error` pulse, then `result`=0x04030201.
- Send two full words (0x00000001, then 0x00000002) with no `start`, then `start` twice → one `error` pulse (overrun); first `done` gives `result`=0x00000001; second request waits.
- Pulse `start` with `clock_en`=0 while a word is held → no `done`. Assert `reset` low mid-byte → all outputs 0, and the next clean word is received correctly.
- With `UART_WORD_RX_TIMEOUT_EN`: send 0xAA, idle for 20 bit-times, then send 0x01, 0x02, 0x03, 0x04 → `error` pulse, then `result`=0x04030201.
